// File: rtl/font_text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : font_text_blitter
// Description : Draws a string of 8-pixel-wide glyphs into the frame buffer
//               as 4-bit palette indices. Fetches character codes from the
//               requester's string buffer and glyph rows from the font ROM,
//               then issues one back-pressured frame-buffer write per pixel.
//               Off-screen pixels and transparent background pixels are
//               skipped in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module font_text_blitter #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int FB_AW    = 17,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [9:0]       x0_i,
    input  logic [8:0]       y0_i,
    input  logic [4:0]       len_i,
    input  logic [3:0]       fg_index_i,
    input  logic [3:0]       bg_index_i,
    input  logic             transparent_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [3:0]       char_addr_o,
    input  logic [7:0]       char_data_i,
    output logic [10:0]      font_addr_o,
    input  logic [7:0]       font_data_i,
    output logic             fb_we_o,
    output logic [FB_AW-1:0] fb_addr_o,
    output logic [3:0]       fb_wdata_o,
    input  logic             fb_ready_i
);

    localparam logic [10:0] SCREEN_W_C = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_C = 11'(SCREEN_H);
    localparam logic [2:0]  LAST_COL   = 3'(GLYPH_W - 1);
    localparam logic [3:0]  LAST_ROW   = 4'(GLYPH_H - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH_CHAR = 3'd1,
        S_WAIT_CHAR  = 3'd2,
        S_FETCH_ROW  = 3'd3,
        S_WAIT_ROW   = 3'd4,
        S_DRAW       = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t             state_q;
    logic [9:0]         x0_q;
    logic [8:0]         y0_q;
    logic [4:0]         len_q;
    logic [3:0]         fg_q;
    logic [3:0]         bg_q;
    logic               tr_q;
    logic [4:0]         c_q;        // wide enough that len up to 31 never wraps
    logic [3:0]         r_q;
    logic [2:0]         k_q;
    logic [6:0]         code_q;
    logic [7:0]         bits_q;

    logic               ready_q;
    logic               done_q;
    logic [3:0]         char_addr_q;
    logic [10:0]        font_addr_q;
    logic               fb_we_q;
    logic [FB_AW-1:0]   fb_addr_q;
    logic [3:0]         fb_wdata_q;

    // Evaluation of the pixel that will be presented next cycle
    logic [2:0]         eval_k_d;
    logic [7:0]         eval_bits_d;
    logic [10:0]        px_d;
    logic [10:0]        py_d;
    logic [21:0]        lin_d;
    logic               pix_bit_d;
    logic               pix_we_d;
    logic [FB_AW-1:0]   pix_addr_d;
    logic [3:0]         pix_data_d;

    // Bit 7 of the character code selects nothing in a 128-glyph font
    logic               unused_code_msb;
    assign unused_code_msb = char_data_i[7];

    // Next pixel's position, visibility and write value; on row entry the
    // glyph row comes straight from the ROM, otherwise from the held row
    always_comb begin
        eval_k_d    = (state_q == S_WAIT_ROW) ? 3'd0 : k_q + 3'd1;
        eval_bits_d = (state_q == S_WAIT_ROW) ? font_data_i : bits_q;
        px_d        = 11'(x0_q) + 11'({c_q, 3'b000}) + 11'(eval_k_d);
        py_d        = 11'(y0_q) + 11'(r_q);
        lin_d       = 22'(py_d) * 22'(SCREEN_W) + 22'(px_d);
        pix_bit_d   = eval_bits_d[3'd7 - eval_k_d];
        pix_we_d    = (px_d < SCREEN_W_C) && (py_d < SCREEN_H_C) &&
                      !(tr_q && !pix_bit_d);
        pix_addr_d  = FB_AW'(lin_d);
        pix_data_d  = pix_bit_d ? fg_q : bg_q;
    end

    // Request sequencer with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            len_q       <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            tr_q        <= 1'b0;
            c_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            code_q      <= '0;
            bits_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            char_addr_q <= '0;
            font_addr_q <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x0_q    <= x0_i;
                        y0_q    <= y0_i;
                        len_q   <= len_i;
                        fg_q    <= fg_index_i;
                        bg_q    <= bg_index_i;
                        tr_q    <= transparent_i;
                        ready_q <= 1'b0;
                        if (len_i != 5'd0) begin
                            c_q         <= '0;
                            char_addr_q <= '0;
                            state_q     <= S_FETCH_CHAR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH_CHAR: begin
                    state_q <= S_WAIT_CHAR;
                end
                S_WAIT_CHAR: begin
                    code_q      <= char_data_i[6:0];
                    r_q         <= '0;
                    font_addr_q <= {char_data_i[6:0], 4'd0};
                    state_q     <= S_FETCH_ROW;
                end
                S_FETCH_ROW: begin
                    state_q <= S_WAIT_ROW;
                end
                S_WAIT_ROW: begin
                    bits_q  <= font_data_i;
                    k_q     <= '0;
                    fb_we_q <= pix_we_d;
                    if (pix_we_d) begin
                        fb_addr_q  <= pix_addr_d;
                        fb_wdata_q <= pix_data_d;
                    end
                    state_q <= S_DRAW;
                end
                S_DRAW: begin
                    // A pending write holds everything until accepted
                    if (!fb_we_q || fb_ready_i) begin
                        if (k_q != LAST_COL) begin
                            k_q     <= k_q + 3'd1;
                            fb_we_q <= pix_we_d;
                            if (pix_we_d) begin
                                fb_addr_q  <= pix_addr_d;
                                fb_wdata_q <= pix_data_d;
                            end
                        end else begin
                            fb_we_q <= 1'b0;
                            if (r_q != LAST_ROW) begin
                                r_q         <= r_q + 4'd1;
                                font_addr_q <= {code_q, r_q + 4'd1};
                                state_q     <= S_FETCH_ROW;
                            end else if (c_q != len_q - 5'd1) begin
                                c_q         <= c_q + 5'd1;
                                char_addr_q <= 4'(c_q + 5'd1);
                                state_q     <= S_FETCH_CHAR;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    fb_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign char_addr_o = char_addr_q;
    assign font_addr_o = font_addr_q;
    assign fb_we_o     = fb_we_q;
    assign fb_addr_o   = fb_addr_q;
    assign fb_wdata_o  = fb_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_font_text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_font_text_blitter
// Description : Self-checking bench for font_text_blitter. Models the string
//               buffer and font ROM as 1-cycle synchronous memories and
//               predicts each request's writes and completion cycle from the
//               drawing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_font_text_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [4:0]  len;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        tr;
    logic        ready;
    logic        done;
    logic [3:0]  char_addr;
    logic [7:0]  char_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [3:0]  fb_wdata;
    logic        fb_ready;

    logic [7:0]  str_mem  [16];
    logic [7:0]  font_mem [2048];

    typedef struct {
        logic [16:0] a;
        logic [3:0]  d;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    font_text_blitter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .x0_i          (x0),
        .y0_i          (y0),
        .len_i         (len),
        .fg_index_i    (fg),
        .bg_index_i    (bg),
        .transparent_i (tr),
        .ready_o       (ready),
        .done_o        (done),
        .char_addr_o   (char_addr),
        .char_data_i   (char_data),
        .font_addr_o   (font_addr),
        .font_data_i   (font_data),
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_wdata_o    (fb_wdata),
        .fb_ready_i    (fb_ready)
    );

    // Synchronous string buffer and font ROM
    always @(posedge clk) begin
        char_data <= str_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every pixel that must land in the frame buffer, in drawing order
    task automatic build_model(input logic [9:0] x, input logic [8:0] y, input logic [4:0] l,
                               input logic [3:0] f, input logic [3:0] bgi, input logic t);
        exp_q.delete();
        for (int c = 0; c < int'(l); c++) begin
            for (int r = 0; r < 16; r++) begin
                logic [7:0]  code;
                logic [10:0] fa;
                logic [7:0]  bits;
                code = str_mem[c];
                fa   = {code[6:0], 4'(r)};
                bits = font_mem[fa];
                for (int k = 0; k < 8; k++) begin
                    int px;
                    int py;
                    logic pbit;
                    wr_t w;
                    px   = int'(x) + 8 * c + k;
                    py   = int'(y) + r;
                    pbit = bits[7 - k];
                    if (px < 320 && py < 240 && !(t && !pbit)) begin
                        w.a = 17'(py * 320 + px);
                        w.d = pbit ? f : bgi;
                        exp_q.push_back(w);
                    end
                end
            end
        end
    endtask

    // One request: start, watch every cycle, score writes and completion time
    task automatic run_req(input logic [9:0] x, input logic [8:0] y, input logic [4:0] l,
                           input logic [3:0] f, input logic [3:0] bgi, input logic t,
                           input int stall_first, input bit rnd_rdy, input int busy_cyc,
                           input int exp_cnt, input string tag);
        int          nwr;
        int          stalls;
        int          stall_left;
        int          done_cyc;
        int          budget;
        int          exp_n;
        bit          prev_stall;
        logic [16:0] pa;
        logic [3:0]  pd;
        wr_t         e;
        build_model(x, y, l, f, bgi, t);
        exp_n      = exp_q.size();
        nwr        = 0;
        stalls     = 0;
        stall_left = stall_first;
        done_cyc   = -1;
        prev_stall = 1'b0;
        pa         = '0;
        pd         = '0;
        budget     = int'(l) * 162 * 4 + stall_first + 100;
        @(negedge clk);
        check({tag, "_ready_idle"}, ready, 1);
        start    = 1'b1;
        x0       = x;
        y0       = y;
        len      = l;
        fg       = f;
        bg       = bgi;
        tr       = t;
        fb_ready = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            // captured request must not follow later input activity
            start = (cyc == busy_cyc);
            x0    = 10'($urandom);
            y0    = 9'($urandom);
            len   = 5'($urandom_range(1, 16));
            fg    = 4'($urandom);
            bg    = 4'($urandom);
            tr    = 1'($urandom);
            if (cyc == 1)
                check({tag, "_ready_busy"}, ready, 0);
            if (prev_stall) begin
                check({tag, "_stall_we"}, fb_we, 1);
                check({tag, "_stall_addr"}, fb_addr, pa);
                check({tag, "_stall_data"}, fb_wdata, pd);
            end
            if (fb_we === 1'b1) begin
                if (stall_left > 0 || (rnd_rdy && $urandom_range(0, 2) == 0)) begin
                    if (stall_left > 0)
                        stall_left--;
                    fb_ready   = 1'b0;
                    stalls++;
                    prev_stall = 1'b1;
                    pa         = fb_addr;
                    pd         = fb_wdata;
                end else begin
                    fb_ready   = 1'b1;
                    prev_stall = 1'b0;
                    stall_left = 0;
                    nwr++;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_write"}, fb_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_wr_addr"}, fb_addr, e.a);
                        check({tag, "_wr_data"}, fb_wdata, e.d);
                    end
                end
            end else begin
                fb_ready   = rnd_rdy ? 1'($urandom) : 1'b1;
                prev_stall = 1'b0;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, int'(l) * 162 + 1 + stalls);
        check({tag, "_write_count"}, nwr, exp_n);
        if (exp_cnt >= 0)
            check({tag, "_write_total"}, nwr, exp_cnt);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        logic [3:0] ca_before;
        int         stray;
        rst      = 1'b1;
        start    = 1'b0;
        x0       = '0;
        y0       = '0;
        len      = '0;
        fg       = '0;
        bg       = '0;
        tr       = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            str_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++)
            font_mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_char_addr", char_addr, 0);
        check("rst_font_addr", font_addr, 0);
        rst = 1'b0;

        // single glyph at the origin, everything drawn
        str_mem[0] = 8'h41;
        run_req(10'd0, 9'd0, 5'd1, 4'hF, 4'h1, 1'b0, 0, 1'b0, -1, 128, "t1");

        // second glyph entirely beyond the right edge
        str_mem[0] = 8'($urandom);
        str_mem[1] = 8'($urandom);
        run_req(10'd312, 9'd0, 5'd2, 4'h7, 4'h2, 1'b0, 0, 1'b0, -1, 128, "t2");

        // transparent background with only the outer columns set
        for (int i = 0; i < 2048; i++)
            font_mem[i] = 8'h81;
        run_req(10'd0, 9'd0, 5'd1, 4'hC, 4'h3, 1'b1, 0, 1'b0, -1, 32, "t3");
        for (int i = 0; i < 2048; i++)
            font_mem[i] = 8'($urandom);

        // three-cycle stall on the first write
        run_req(10'd0, 9'd0, 5'd1, 4'hA, 4'h5, 1'b0, 3, 1'b0, -1, 128, "t4");

        // empty string
        ca_before = char_addr;
        run_req(10'd5, 9'd5, 5'd0, 4'h1, 4'h2, 1'b0, 0, 1'b0, -1, 0, "t5");
        check("t5_no_fetch", char_addr, ca_before);

        // random requests near the screen edges, random back-pressure,
        // a stray start while busy
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++)
                str_mem[i] = 8'($urandom);
            run_req(10'($urandom_range(250, 330)), 9'($urandom_range(220, 245)),
                    5'($urandom_range(1, 5)), 4'($urandom), 4'($urandom), 1'($urandom),
                    0, 1'b1, 20, -1, "t6");
        end

        // reset in the middle of drawing
        @(negedge clk);
        start = 1'b1;
        x0    = 10'd0;
        y0    = 9'd0;
        len   = 5'd3;
        fg    = 4'h9;
        bg    = 4'h4;
        tr    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("t7_pre_busy", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_we", fb_we, 0);
        check("t7_rst_ready", ready, 1);
        check("t7_rst_done", done, 0);
        rst   = 1'b0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (fb_we !== 1'b0)
                stray++;
        end
        check("t7_no_writes", stray, 0);
        check("t7_ready_idle", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/font_text_blitter.md
Name: font_text_blitter

Overview:
- Sequencer that draws a string of glyphs into the frame buffer as 4-bit palette indices. The palette stage resolves those indices to RGB at scan-out.
- Accepts one draw request at a time. Fetches character codes from the requester's string buffer and glyph rows from the font ROM, then emits one frame-buffer write per pixel with back-pressure.
- Sits between the game logic (requester) and the frame-buffer write port, alongside the font ROM and palette.

Parameters:
- SCREEN_W, 320, frame-buffer width in pixels (row pitch for address calculation)
- SCREEN_H, 240, frame-buffer height in pixels
- FB_AW, 17, frame-buffer address width
- GLYPH_W, 8, glyph width in pixels; fixed by the font ROM row width
- GLYPH_H, 16, glyph height in rows

Ports:
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- x0  in  10  left pixel column of first glyph
- y0  in  9  top pixel row
- len  in  5  number of characters, 0..16
- fg_index  in  4  palette index for glyph bit = 1
- bg_index  in  4  palette index for glyph bit = 0
- transparent  in  1  1 = glyph bit 0 pixels are not written
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse at request completion
- char_addr  out  4  string buffer read address (character index)
- char_data  in  8  character code; valid 1 cycle after char_addr issued
- font_addr  out  11  {char_code[6:0], row[3:0]}
- font_data  in  8  glyph row; valid 1 cycle after font_addr issued; bit 7 = leftmost pixel
- fb_we  out  1  write request
- fb_addr  out  FB_AW  y*SCREEN_W + x
- fb_wdata  out  4  palette index
- fb_ready  in  1  write accepted on cycles where fb_we && fb_ready

Behaviour:
- Reset:
  - state = IDLE; done, fb_we, char_addr, font_addr, fb_addr, fb_wdata = 0; ready = 1.
  - Reset mid-request abandons the request; no further writes occur.
- Request capture:
  - In IDLE, start=1 latches x0, y0, len, fg/bg_index and transparent.
  - start outside IDLE is ignored; input changes after capture have no effect.
- State IDLE:
  - start && len!=0 -> FETCH_CHAR, char index c=0.
  - start && len==0 -> DONE.
- FETCH_CHAR: drive char_addr=c -> WAIT_CHAR.
- WAIT_CHAR:
  - Register char_data as code.
  - row r=0 -> FETCH_ROW.
- FETCH_ROW: drive font_addr={code[6:0], r} -> WAIT_ROW.
- WAIT_ROW:
  - Register font_data as bits.
  - column k=0 -> DRAW.
- DRAW, one pixel per step:
  - Pixel position: px = x0 + 8*c + k, py = y0 + r. Computed at ≥11 bits; never wraps.
  - Pixel value: bit = bits[7-k].
  - Skip the pixel (no fb_we, advance immediately, 1 cycle) if px >= SCREEN_W, py >= SCREEN_H, or (transparent && bit==0).
  - Otherwise:
    - Drive fb_we=1, fb_addr=py*SCREEN_W+px, fb_wdata = bit ? fg_index : bg_index.
    - Hold all three stable until fb_ready=1, then advance.
  - After k=7:
    - r<15 -> r++, FETCH_ROW.
    - r==15 && c<len-1 -> c++, FETCH_CHAR.
    - r==15 && c==len-1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE; ready returns 1 the following cycle.
- Timing with fb_ready held high:
  - Each character takes 2 + 16*(2+8) = 162 cycles.
  - done is high in cycle len*162+1, where the start cycle is cycle 0.
  - Each fb_ready-low cycle on a pending write adds one cycle.
- fb_we is never asserted outside DRAW. char_addr and font_addr hold their last value when not fetching.
- Codes >= 128 use code[6:0]; bit 7 is ignored.

Test Plan:
- Reset, then start x0=0,y0=0,len=1,fg=0xF,bg=0x1,transparent=0, char 0x41, fb_ready=1 -> exactly 128 writes. First write is fb_addr=0. Addresses are row-major within the glyph, with data matching the ROM bits. done in cycle 163.
- len=2 at x0=312,y0=0 -> char 0 is fully drawn (columns 312..319). Char 1 is entirely clipped: 0 writes for it. done in cycle 325.
- transparent=1, glyph row 0x81 in every row -> exactly 32 writes (columns 0 and 7 only), all with data fg_index.
- fb_ready low for 3 cycles on the first write -> fb_we, fb_addr and fb_wdata held stable through the stall. Write count unchanged, done delayed by 3 cycles.
- len=0 -> no fetches and no writes; done in cycle 1. start asserted while busy -> ignored, no second request.
- Reset asserted mid-DRAW -> the next cycle shows IDLE, fb_we=0, ready=1, and no writes until a new start.
